// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Pixel-source bus between the VGA timing generator and a frame buffer or
//   pixel producer. The generator requests a position, and the source answers
//   with colour data a fixed number of en-cycles later.
//
//   Signals:
//     pix_req   generator -> source  current position is visible
//     pix_x     generator -> source  requested column (valid with pix_req)
//     pix_y     generator -> source  requested row    (valid with pix_req)
//     pix_r/g/b source -> generator  colour components
//
//   Modports:
//     master  timing generator side
//     slave   pixel source side
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int COLOR_WIDTH = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
);
  logic                   pix_req;
  logic [X_W-1:0]         pix_x;
  logic [Y_W-1:0]         pix_y;
  logic [COLOR_WIDTH-1:0] pix_r;
  logic [COLOR_WIDTH-1:0] pix_g;
  logic [COLOR_WIDTH-1:0] pix_b;

  modport master (
    output pix_req, pix_x, pix_y,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator with a registered pixel output
//   stage. Walks the raster with horizontal/vertical counters, requests
//   visible pixels from a source over pix_bus, realigns sync/blanking to the
//   source read latency and drives registered sync and colour pins. A built-in
//   8-bar colour pattern can replace the source data.
//
//   Ports:
//     clk          system clock
//     rst          asynchronous active-high reset
//     en           pixel-clock enable; all state advances only when en=1
//     pattern_en   1 = output colour bars instead of source data
//     pix_bus      pixel request / data bus (master side)
//     HSync/VSync  registered sync outputs, polarity per HSYNC_POL/VSYNC_POL
//     RED/GREEN/BLUE registered colour outputs, zero during blanking
//     frame_start  one-en-cycle pulse aligned with output of pixel (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int COLOR_WIDTH = 4,
  parameter int PIX_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   pattern_en,
  vga_timing_gen_if.master       pix_bus,
  output logic                   HSync,
  output logic                   VSync,
  output logic [COLOR_WIDTH-1:0] RED,
  output logic [COLOR_WIDTH-1:0] GREEN,
  output logic [COLOR_WIDTH-1:0] BLUE,
  output logic                   frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int X_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  // One delay-line tap: everything that has to line up with the source data.
  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] bar;
  } tap_t;

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic [31:0]    w_h32;
  logic [31:0]    w_v32;
  logic           w_h_last;
  logic           w_v_last;

  // Zero-extended copies so every window compare is done in 32 bits; a window
  // end may equal the total, which would not fit in the counter width.
  assign w_h32    = 32'(r_h_cnt);
  assign w_v32    = 32'(r_v_cnt);
  assign w_h_last = (w_h32 == 32'(H_TOTAL - 1));
  assign w_v_last = (w_v32 == 32'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Position decode
  // -------------------------------------------------------------------------
  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic       w_fs;
  logic [2:0] w_bar;
  tap_t       w_tap;

  assign w_active = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
  assign w_hs     = (w_h32 >= 32'(HS_START)) && (w_h32 < 32'(HS_END));
  assign w_vs     = (w_v32 >= 32'(VS_START)) && (w_v32 < 32'(VS_END));
  assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);
  // Only meaningful inside the visible area, where h_cnt < H_ACTIVE keeps the
  // quotient in 0..7.
  assign w_bar    = 3'(w_h32 / 32'(BAR_W));

  assign w_tap.active = w_active;
  assign w_tap.hs     = w_hs;
  assign w_tap.vs     = w_vs;
  assign w_tap.fs     = w_fs;
  assign w_tap.bar    = w_bar;

  // -------------------------------------------------------------------------
  // Pixel request
  // -------------------------------------------------------------------------
  // Qualified with en and rst so the source never sees a request that the
  // counters will not act on.
  assign pix_bus.pix_req = w_active & en & ~rst;
  assign pix_bus.pix_x   = X_W'(r_h_cnt);
  assign pix_bus.pix_y   = Y_W'(r_v_cnt);

  // -------------------------------------------------------------------------
  // Delay line: PIX_LATENCY en-gated stages so that timing info arrives at the
  // output register in the same en-cycle as the source data it belongs to.
  // -------------------------------------------------------------------------
  tap_t r_dl [PIX_LATENCY];
  tap_t w_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIX_LATENCY; i++) begin
        r_dl[i] <= '0;
      end
    end else if (en) begin
      r_dl[0] <= w_tap;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        r_dl[i] <= r_dl[i-1];
      end
    end
  end

  assign w_dly = r_dl[PIX_LATENCY-1];

  // -------------------------------------------------------------------------
  // Colour bars: white, yellow, cyan, green, magenta, red, blue, black.
  // Red is off for indices with bit1 set, green off for bit2, blue off for
  // bit0, which yields exactly that sequence.
  // -------------------------------------------------------------------------
  logic [COLOR_WIDTH-1:0] w_bar_r;
  logic [COLOR_WIDTH-1:0] w_bar_g;
  logic [COLOR_WIDTH-1:0] w_bar_b;

  assign w_bar_r = {COLOR_WIDTH{~w_dly.bar[1]}};
  assign w_bar_g = {COLOR_WIDTH{~w_dly.bar[2]}};
  assign w_bar_b = {COLOR_WIDTH{~w_dly.bar[0]}};

  // -------------------------------------------------------------------------
  // Output register. Source data is captured here directly, at the end of the
  // en-cycle in which the delayed tap for the same position is presented.
  // pattern_en is sampled here too, so a change takes effect on the next
  // output pixel without any synchronisation.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HSync       <= ~HS_ACT;
      VSync       <= ~VS_ACT;
      RED         <= '0;
      GREEN       <= '0;
      BLUE        <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      HSync       <= w_dly.hs ? HS_ACT : ~HS_ACT;
      VSync       <= w_dly.vs ? VS_ACT : ~VS_ACT;
      frame_start <= w_dly.fs;
      if (!w_dly.active) begin
        RED   <= '0;
        GREEN <= '0;
        BLUE  <= '0;
      end else if (pattern_en) begin
        RED   <= w_bar_r;
        GREEN <= w_bar_g;
        BLUE  <= w_bar_b;
      end else begin
        RED   <= pix_bus.pix_r;
        GREEN <= pix_bus.pix_g;
        BLUE  <= pix_bus.pix_b;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen on a 16x8 raster (8x4 visible,
//   PIX_LATENCY=2). Two instances share clk/rst/en/pattern_en: one with
//   active-low syncs, one with active-high syncs.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pat;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_WIDTH(4), .X_W(3), .Y_W(2)) bus_a ();
  vga_timing_gen_if #(.COLOR_WIDTH(4), .X_W(3), .Y_W(2)) bus_b ();

  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  // Pixel source: R = x, G = y, B = F, two en-cycles of read latency.
  logic [3:0] s1_r = '0, s1_g = '0, s2_r = '0, s2_g = '0;

  always @(posedge clk) begin
    if (en) begin
      s1_r <= {1'b0, bus_a.pix_x};
      s1_g <= {2'b00, bus_a.pix_y};
      s2_r <= s1_r;
      s2_g <= s1_g;
    end
  end

  assign bus_a.pix_r = s2_r;
  assign bus_a.pix_g = s2_g;
  assign bus_a.pix_b = 4'hF;
  assign bus_b.pix_r = s2_r;
  assign bus_b.pix_g = s2_g;
  assign bus_b.pix_b = 4'hF;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_WIDTH(4), .PIX_LATENCY(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .pattern_en(pat), .pix_bus(bus_a),
    .HSync(hs_a), .VSync(vs_a), .RED(r_a), .GREEN(g_a), .BLUE(b_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_WIDTH(4), .PIX_LATENCY(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .pattern_en(pat), .pix_bus(bus_b),
    .HSync(hs_b), .VSync(vs_b), .RED(r_b), .GREEN(g_b), .BLUE(b_b),
    .frame_start(fs_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exv);
    n_tests++;
    assert (obs === exv)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exv);
    end
  endtask

  function automatic logic [11:0] bar_rgb(input int h);
    case (h)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Expected {HSync, VSync, frame_start, R, G, B} during en-cycle e after
  // reset release. Output of en-cycle e shows position e-3 (request plus two
  // latency cycles plus the output register).
  function automatic logic [14:0] exp_out(input int e, input logic p,
                                          input logic pol);
    int q, h, v;
    logic act, hs, vs, fs;
    logic [11:0] rgb;
    if (e < 3) return {~pol, ~pol, 1'b0, 12'h000};
    q   = e - 3;
    h   = q % 16;
    v   = (q / 16) % 8;
    act = (h < 8) && (v < 4);
    hs  = (h >= 10) && (h <= 12);
    vs  = (v == 5) || (v == 6);
    fs  = (q % 128) == 0;
    if (!act)   rgb = 12'h000;
    else if (p) rgb = bar_rgb(h);
    else        rgb = {4'(h), 4'(v), 4'hF};
    return {pol ? hs : ~hs, pol ? vs : ~vs, fs, rgb};
  endfunction

  // Full check of both instances for en-cycle e (wall cycle cyc).
  task automatic check_cycle(input int e, input int cyc);
    logic [14:0] xa, xb;
    logic act;
    xa  = exp_out(e, pat, 1'b0);
    xb  = exp_out(e, pat, 1'b1);
    act = ((e % 16) < 8) && (((e / 16) % 8) < 4);
    chk("hsync_lo", cyc, hs_a, xa[14]);
    chk("vsync_lo", cyc, vs_a, xa[13]);
    chk("frame_start", cyc, fs_a, xa[12]);
    chk("rgb", cyc, {r_a, g_a, b_a}, xa[11:0]);
    chk("pix_req", cyc, bus_a.pix_req, en & act);
    if (en && act) begin
      chk("pix_x", cyc, bus_a.pix_x, e % 16);
      chk("pix_y", cyc, bus_a.pix_y, (e / 16) % 8);
    end
    chk("hsync_hi", cyc, hs_b, xb[14]);
    chk("vsync_hi", cyc, vs_b, xb[13]);
    chk("frame_start_hi", cyc, fs_b, xb[12]);
  endtask

  task automatic run_free(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      check_cycle(c, c);
      if (c == 3)  chk("fs_first", c, fs_a, 1);
      if (c == 40 && !pat) chk("px_line2_col5", c, {r_a, g_a, b_a}, 12'h52F);
      if (c == 131) chk("fs_period", c, fs_a, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    int e;
    rst = 1'b1;
    en  = 1'b1;
    pat = 1'b0;

    // Reset values while held in reset with en high.
    @(negedge clk);
    #1;
    chk("rst_hsync_lo", -1, hs_a, 1);
    chk("rst_vsync_lo", -1, vs_a, 1);
    chk("rst_rgb", -1, {r_a, g_a, b_a}, 0);
    chk("rst_fs", -1, fs_a, 0);
    chk("rst_pix_req", -1, bus_a.pix_req, 0);
    chk("rst_hsync_hi", -1, hs_b, 0);
    chk("rst_vsync_hi", -1, vs_b, 0);

    // Free run with source data: sync timing, pixel path, blanking.
    @(negedge clk);
    rst = 1'b0;
    run_free(301);

    // Mid-frame reset while HSync is low; outputs must reset before the edge.
    #1;
    chk("hsync_low_before_rst", 301, hs_a, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_hsync", 301, hs_a, 1);
    chk("mid_rst_vsync", 301, vs_a, 1);
    chk("mid_rst_rgb", 301, {r_a, g_a, b_a}, 0);
    chk("mid_rst_fs", 301, fs_a, 0);
    chk("mid_rst_pix_req", 301, bus_a.pix_req, 0);
    chk("mid_rst_hsync_hi", 301, hs_b, 0);
    chk("mid_rst_vsync_hi", 301, vs_b, 0);

    // Colour-bar pattern mode.
    @(negedge clk);
    rst = 1'b0;
    pat = 1'b1;
    run_free(140);

    // Enable gating with en = 1,0,0,1 repeating.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pat = 1'b0;
    e   = 0;
    for (int w = 0; w < 400; w++) begin
      en = ((w % 4) == 0) || ((w % 4) == 3);
      #1;
      check_cycle(e, w);
      @(negedge clk);
      if (en) e++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
